// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the FIFO read port, the reader engine and the
// downstream stream consumer. The reader takes the master side.
interface fifo_stream_reader_if #(
    parameter int unsigned WIDTH = 32
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_pop;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    modport master (
        input  fifo_empty, fifo_rdata, m_ready,
        output fifo_pop, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_rdata, m_ready,
        input  fifo_pop, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO into a registered valid/ready stream, one
// BURST_LEN-word burst per start command, tagging the final word with m_last.
module fifo_stream_reader #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BURST_LEN = 784
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    fifo_stream_reader_if.master bus
);
    localparam int unsigned CNT_WIDTH = $clog2(BURST_LEN + 1);
    localparam logic [CNT_WIDTH-1:0] LEN  = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(BURST_LEN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q,   state_d;
    logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
    logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
    logic                 m_valid_q, m_valid_d;
    logic [WIDTH-1:0]     m_data_q,  m_data_d;
    logic                 m_last_q,  m_last_d;

    logic accept;
    logic slot_free;
    logic pop;

    assign accept    = m_valid_q && bus.m_ready;
    assign slot_free = !m_valid_q || bus.m_ready;
    // Gated by reset so the FIFO never loses a word while the engine is held.
    assign pop = reset && (state_q == ST_RUN) && !bus.fifo_empty
                 && (pop_cnt_q < LEN) && slot_free;

    always_comb begin
        state_d   = state_q;
        pop_cnt_d = pop_cnt_q;
        acc_cnt_d = acc_cnt_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    pop_cnt_d = '0;
                    acc_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (accept && m_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (pop) begin
            m_data_d  = bus.fifo_rdata;
            m_valid_d = 1'b1;
            m_last_d  = (pop_cnt_q == LAST);
            pop_cnt_d = pop_cnt_q + 1'b1;
        end else if (accept) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (accept) begin
            acc_cnt_d = acc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pop_cnt_q <= '0;
            acc_cnt_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pop_cnt_q <= pop_cnt_d;
            acc_cnt_q <= acc_cnt_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
        end
    end

    assign bus.fifo_pop = pop;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_last   = m_last_q;
    assign busy         = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign done         = (state_q == ST_DONE);

`ifndef SYNTHESIS
    counters_ordered: assert property (@(posedge clk) disable iff (!reset)
        (acc_cnt_q <= pop_cnt_q) && (pop_cnt_q <= LEN));
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: two readers (BURST_LEN 4 and 1) fed from simple show-ahead
// FIFO models; each scenario checks a per-cycle table of expected outputs.
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start0 = 1'b0;
    logic start1 = 1'b0;
    logic busy0, done0, busy1, done1;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.WIDTH(32)) bus0 ();
    fifo_stream_reader_if #(.WIDTH(32)) bus1 ();

    fifo_stream_reader #(.WIDTH(32), .BURST_LEN(4)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .bus(bus0.master)
    );
    fifo_stream_reader #(.WIDTH(32), .BURST_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .bus(bus1.master)
    );

    // Show-ahead FIFO models: pushes from the stimulus, pops from the DUT strobe.
    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];
    int unsigned wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    logic rdy0 = 1'b1;
    logic rdy1 = 1'b1;

    assign bus0.fifo_empty = (wr0 == rd0);
    assign bus0.fifo_rdata = mem0[rd0[5:0]];
    assign bus0.m_ready    = rdy0;
    assign bus1.fifo_empty = (wr1 == rd1);
    assign bus1.fifo_rdata = mem1[rd1[5:0]];
    assign bus1.m_ready    = rdy1;

    always @(posedge clk) begin
        if (bus0.fifo_pop) rd0 <= rd0 + 1;
        if (bus1.fifo_pop) rd1 <= rd1 + 1;
    end

    task automatic push0(input logic [31:0] v);
        mem0[wr0[5:0]] = v;
        wr0 = wr0 + 1;
    endtask

    task automatic push1(input logic [31:0] v);
        mem1[wr1[5:0]] = v;
        wr1 = wr1 + 1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rdy0  = 1'b1;
        rdy1  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wr0   = rd0;
        wr1   = rd1;
        reset = 1'b1;
    endtask

    task automatic preload_a();
        for (int i = 0; i < 6; i++) push0(32'hA0 + 32'(i));
    endtask

    task automatic pulse_start0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset = 1'b0;
        push0(32'hA0);
        push1(32'h55);
        repeat (2) @(posedge clk);
        #1;
        obs = {bus0.fifo_pop, bus0.m_valid, bus0.m_last, done0, busy0, bus1.fifo_pop};
        n_vec++;
        if (obs !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b exp 000000", obs);
        end
        obs = {bus1.m_valid, bus1.m_last, done1, busy1, 2'b00};
        n_vec++;
        if (obs !== 6'b0) begin
            n_err++;
            $display("FAIL reset_flags1 got %b exp 000000", obs);
        end
        n_vec++;
        if (bus0.m_data !== 32'h0 || bus1.m_data !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data got %h/%h exp 0/0", bus0.m_data, bus1.m_data);
        end
        n_vec++;
        if ((wr0 - rd0) !== 1 || (wr1 - rd1) !== 1) begin
            n_err++;
            $display("FAIL reset_nopop got %0d/%0d exp 1/1", wr0 - rd0, wr1 - rd1);
        end
        do_reset();
    endtask

    // Flag vectors are {fifo_pop, m_valid, m_last, done, busy}.
    task automatic test_basic();
        logic [4:0]  ef [7];
        logic [31:0] ed [7];
        logic [4:0]  obs;
        ef = '{5'b10001, 5'b11001, 5'b11001, 5'b11001, 5'b01101, 5'b00011, 5'b00000};
        ed = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0};
        do_reset();
        preload_a();
        pulse_start0();
        for (int k = 0; k < 7; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            #1;
            obs = {bus0.fifo_pop, bus0.m_valid, bus0.m_last, done0, busy0};
            n_vec++;
            if (obs !== ef[k]) begin
                n_err++;
                $display("FAIL basic_flags k=%0d got %b exp %b", k, obs, ef[k]);
            end
            if (ef[k][3]) begin
                n_vec++;
                if (bus0.m_data !== ed[k]) begin
                    n_err++;
                    $display("FAIL basic_data k=%0d got %h exp %h", k, bus0.m_data, ed[k]);
                end
            end
        end
        n_vec++;
        if ((wr0 - rd0) !== 2 || bus0.fifo_rdata !== 32'hA4) begin
            n_err++;
            $display("FAIL basic_leftover got %0d head %h exp 2 head a4", wr0 - rd0, bus0.fifo_rdata);
        end
    endtask

    task automatic test_backpressure();
        logic [4:0]  ef [10];
        logic [31:0] ed [10];
        logic        rd [10];
        logic [4:0]  obs;
        ef = '{5'b10001, 5'b01001, 5'b01001, 5'b01001, 5'b11001,
               5'b11001, 5'b11001, 5'b01101, 5'b00011, 5'b00000};
        ed = '{32'h0, 32'hA0, 32'hA0, 32'hA0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0};
        rd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        preload_a();
        pulse_start0();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            rdy0 = rd[k];
            #1;
            obs = {bus0.fifo_pop, bus0.m_valid, bus0.m_last, done0, busy0};
            n_vec++;
            if (obs !== ef[k]) begin
                n_err++;
                $display("FAIL bp_flags k=%0d got %b exp %b", k, obs, ef[k]);
            end
            if (ef[k][3]) begin
                n_vec++;
                if (bus0.m_data !== ed[k]) begin
                    n_err++;
                    $display("FAIL bp_data k=%0d got %h exp %h", k, bus0.m_data, ed[k]);
                end
            end
        end
        n_vec++;
        if ((wr0 - rd0) !== 2) begin
            n_err++;
            $display("FAIL bp_leftover got %0d exp 2", wr0 - rd0);
        end
    endtask

    task automatic test_underrun();
        logic [4:0]  ef [10];
        logic [31:0] ed [10];
        logic [4:0]  obs;
        ef = '{5'b10001, 5'b11001, 5'b01001, 5'b00001, 5'b00001,
               5'b10001, 5'b11001, 5'b01101, 5'b00011, 5'b00000};
        ed = '{32'h0, 32'hB0, 32'hB1, 32'h0, 32'h0, 32'h0, 32'hB2, 32'hB3, 32'h0, 32'h0};
        do_reset();
        push0(32'hB0);
        push0(32'hB1);
        pulse_start0();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 5) begin
                push0(32'hB2);
                push0(32'hB3);
            end
            #1;
            obs = {bus0.fifo_pop, bus0.m_valid, bus0.m_last, done0, busy0};
            n_vec++;
            if (obs !== ef[k]) begin
                n_err++;
                $display("FAIL underrun_flags k=%0d got %b exp %b", k, obs, ef[k]);
            end
            if (ef[k][3]) begin
                n_vec++;
                if (bus0.m_data !== ed[k]) begin
                    n_err++;
                    $display("FAIL underrun_data k=%0d got %h exp %h", k, bus0.m_data, ed[k]);
                end
            end
        end
    endtask

    task automatic test_start_in_run();
        logic [4:0]  ef [10];
        logic [31:0] ed [10];
        logic [4:0]  obs;
        ef = '{5'b10001, 5'b11001, 5'b11001, 5'b11001, 5'b01101,
               5'b00011, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        ed = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();
        preload_a();
        pulse_start0();
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            start0 = (k == 2) || (k == 5);
            #1;
            obs = {bus0.fifo_pop, bus0.m_valid, bus0.m_last, done0, busy0};
            n_vec++;
            if (obs !== ef[k]) begin
                n_err++;
                $display("FAIL startrun_flags k=%0d got %b exp %b", k, obs, ef[k]);
            end
            if (ef[k][3]) begin
                n_vec++;
                if (bus0.m_data !== ed[k]) begin
                    n_err++;
                    $display("FAIL startrun_data k=%0d got %h exp %h", k, bus0.m_data, ed[k]);
                end
            end
        end
        start0 = 1'b0;
        n_vec++;
        if ((wr0 - rd0) !== 2) begin
            n_err++;
            $display("FAIL startrun_leftover got %0d exp 2", wr0 - rd0);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [4:0]  ef [11];
        logic [31:0] ed [11];
        logic [4:0]  obs;
        // Cycles 0-3: abandoned burst (reset low at 2,3); 4-10: fresh burst.
        ef = '{5'b10001, 5'b11001, 5'b01001, 5'b00000,
               5'b10001, 5'b11001, 5'b11001, 5'b11001, 5'b01101, 5'b00011, 5'b00000};
        ed = '{32'h0, 32'hA0, 32'hA1, 32'h0,
               32'h0, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'h0, 32'h0};
        do_reset();
        preload_a();
        pulse_start0();
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 2) reset = 1'b0;
            if (k == 4) begin
                n_vec++;
                if ((wr0 - rd0) !== 4 || bus0.fifo_rdata !== 32'hA2) begin
                    n_err++;
                    $display("FAIL rstmid_retained got %0d head %h exp 4 head a2", wr0 - rd0, bus0.fifo_rdata);
                end
                reset = 1'b1;
                pulse_start0();
            end
            #1;
            obs = {bus0.fifo_pop, bus0.m_valid, bus0.m_last, done0, busy0};
            n_vec++;
            if (obs !== ef[k]) begin
                n_err++;
                $display("FAIL rstmid_flags k=%0d got %b exp %b", k, obs, ef[k]);
            end
            if (ef[k][3] || k == 3) begin
                n_vec++;
                if (bus0.m_data !== ed[k]) begin
                    n_err++;
                    $display("FAIL rstmid_data k=%0d got %h exp %h", k, bus0.m_data, ed[k]);
                end
            end
        end
        n_vec++;
        if (wr0 !== rd0) begin
            n_err++;
            $display("FAIL rstmid_drained got %0d exp 0", wr0 - rd0);
        end
    endtask

    task automatic test_burst_one();
        logic [4:0] ef [4];
        logic [4:0] obs;
        ef = '{5'b10001, 5'b01101, 5'b00011, 5'b00000};
        do_reset();
        push1(32'h55);
        push1(32'h66);
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            #1;
            obs = {bus1.fifo_pop, bus1.m_valid, bus1.m_last, done1, busy1};
            n_vec++;
            if (obs !== ef[k]) begin
                n_err++;
                $display("FAIL len1_flags k=%0d got %b exp %b", k, obs, ef[k]);
            end
            if (ef[k][3]) begin
                n_vec++;
                if (bus1.m_data !== 32'h55) begin
                    n_err++;
                    $display("FAIL len1_data k=%0d got %h exp 55", k, bus1.m_data);
                end
            end
        end
        n_vec++;
        if ((wr1 - rd1) !== 1 || bus1.fifo_rdata !== 32'h66) begin
            n_err++;
            $display("FAIL len1_leftover got %0d head %h exp 1 head 66", wr1 - rd1, bus1.fifo_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_underrun();
        test_start_in_run();
        test_reset_mid_burst();
        test_burst_one();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Read-side engine for the team's synchronous FIFO.
- Drains the FIFO's show-ahead read port (head word valid whenever not empty; pop advances the head) into a registered valid/ready stream for downstream compute (e.g. one 28x28 MNIST image per burst).
- Each start command transfers exactly BURST_LEN words and tags the final word with m_last.
- Issues a one-cycle done pulse when the final word is accepted downstream.

Parameters:
- WIDTH, 32, data width; must match the FIFO WIDTH.
- BURST_LEN, 784, words per burst; legal range 1..65535.
- CNT_WIDTH (localparam), $clog2(BURST_LEN+1), width of the internal word counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0), sampled on rising clk.
- start  input  1  single-cycle burst request; honoured only in IDLE.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse after the last word handshake.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rdata  input  WIDTH  FIFO head word (show-ahead, combinational).
- fifo_pop  output  1  combinational pop strobe to the FIFO.
- m_valid  output  1  stream word valid.
- m_data  output  WIDTH  stream word.
- m_last  output  1  marks the BURST_LEN-th word of the burst.
- m_ready  input  1  downstream accept.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; m_valid=0, m_data=0, m_last=0, done=0, busy=0.
  - Both counters cleared.
  - fifo_pop=0 for as long as reset is low.
- Reset mid-burst: the burst is abandoned and no further pops occur. The FIFO is not flushed; any words left in it remain.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on start==1. Clears pop_cnt and acc_cnt.
  - RUN -> DONE on the clk edge where m_valid && m_ready && m_last.
  - DONE -> IDLE unconditionally after 1 cycle. done=1 only in DONE.
  - start is ignored in RUN and DONE; requests are not queued.
- Output handshake:
  - accept = m_valid && m_ready.
  - slot_free = !m_valid || m_ready.
- Pop:
  - fifo_pop = (state==RUN) && !fifo_empty && (pop_cnt < BURST_LEN) && slot_free.
  - Never asserted while fifo_empty=1. Never more than BURST_LEN pops per burst.
- Output register update on each clk edge:
  - If fifo_pop: m_data<=fifo_rdata, m_valid<=1, m_last<=(pop_cnt==BURST_LEN-1), pop_cnt<=pop_cnt+1.
  - Else if accept: m_valid<=0, m_last<=0. m_data holds its value.
  - m_data/m_valid/m_last are stable while m_valid && !m_ready.
- Latency and throughput:
  - The head word appears on m_data 1 cycle after its pop.
  - Sustained 1 word/cycle when the FIFO is non-empty and m_ready=1.
- acc_cnt increments on each accept. Invariant: acc_cnt <= pop_cnt <= BURST_LEN.
- FIFO underrun mid-burst: stall with no pop and no error. m_valid drops once the held word is accepted. Popping resumes when the FIFO refills.
- BURST_LEN=1: the first popped word has m_last=1.
- busy=1 from the cycle after start through the DONE cycle.
- Width rule: counters are CNT_WIDTH bits, so BURST_LEN is representable and there is no wrap within a burst.

Test Plan:
- BURST_LEN=4; FIFO preloaded with 0xA0..0xA5; start pulse; m_ready=1.
  - Pops on 4 consecutive cycles.
  - m_data=0xA0,0xA1,0xA2,0xA3 on consecutive cycles, m_last only with 0xA3.
  - done pulse 1 cycle after the 0xA3 handshake.
  - 0xA4 and 0xA5 remain in the FIFO, with fifo_pop=0 afterwards.
- Backpressure: same setup, m_ready=0 for 3 cycles after the first m_valid.
  - m_data holds 0xA0 and no further pop during the stall.
  - Stream resumes 0xA1.. with no loss or duplication.
- Underrun: FIFO holds 2 words, BURST_LEN=4.
  - 2 words stream, then m_valid=0, busy=1, no pop on empty.
  - Push 0xB2,0xB3: they stream with m_last on 0xB3, then done.
- start during RUN: second start pulse mid-burst is ignored; exactly 4 words and one done.
- Reset low mid-burst after 2 words: all outputs 0 and state IDLE on the next edge; the FIFO retains the unread words. A new start restarts counting from 0.
- BURST_LEN=1, FIFO holds 0x55: a single word with m_valid=1 and m_last=1, done the cycle after its accept.
